// File: rtl/stream_ready_throttle.sv
// stream_ready_throttle
//   Makes a valid/ready consumer slow or jittery. When a beat is offered, its
//   acceptance (ready_o) is held back for a fixed or LFSR-chosen number of
//   cycles. The beat then lands in a one-entry register that drives the
//   downstream port, so valid_o and payload_o always come straight from flops.
//
// Parameters
//   StallRandom  1: each beat's delay is the LFSR low nibble; 0: use FixedDelay
//   FixedDelay   acceptance delay in cycles, 0..15 (ignored when StallRandom=1)
//   LfsrSeed     LFSR reset value, must be non-zero
//   payload_t    payload type
//
// Ports
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   valid_i    upstream valid
//   ready_o    upstream ready (throttled)
//   payload_i  upstream data
//   valid_o    downstream valid (output register full)
//   ready_i    downstream ready
//   payload_o  downstream data (output register contents)
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no beat in progress; delay sampled when valid_i is seen
// STALL | counting down the remaining delay, ready_o held low
// OPEN  | delay elapsed; ready_o follows output register space

module stream_ready_throttle #(
  parameter bit          StallRandom = 1'b0,
  parameter int unsigned FixedDelay  = 1,
  parameter logic [15:0] LfsrSeed    = 16'hACE1,
  parameter type         payload_t   = logic
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     valid_i,
  output logic     ready_o,
  input  payload_t payload_i,
  output logic     valid_o,
  input  logic     ready_i,
  output payload_t payload_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    OPEN  = 2'd2
  } state_e;

  localparam logic [3:0] FixedDelayNib = FixedDelay[3:0];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        full_q;
  payload_t    data_q;

  logic [3:0]  delay;
  logic        slot_free;
  logic        accept;
  logic        lfsr_fb;
  logic        load;

  assign delay     = StallRandom ? lfsr_q[3:0] : FixedDelayNib;
  assign slot_free = !full_q || ready_i;
  assign accept    = valid_i && ready_o;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  // The LFSR only advances when a delay is loaded, so each beat consumes
  // exactly one value regardless of how long it waits.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign load    = (state_q == IDLE) && valid_i;
  assign lfsr_d  = load ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (delay == 4'd0) begin
            // Zero delay is the only path where ready_o follows valid_i.
            ready_o = slot_free;
            if (!slot_free) begin
              state_d = OPEN;
            end
          end else if (delay == 4'd1) begin
            state_d = OPEN;
          end else begin
            cnt_d   = delay - 4'd1;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = OPEN;
        end
      end
      OPEN: begin
        ready_o = slot_free;
        if (valid_i && slot_free) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lfsr_q  <= LfsrSeed;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Accept wins over pop: a same-cycle pop and accept keeps full_q set
  // and replaces the data, so there is no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      data_q <= payload_i;
    end else if (full_q && ready_i) begin
      full_q <= 1'b0;
    end
  end

  assign valid_o   = full_q;
  assign payload_o = data_q;

`ifndef SYNTHESIS
  // Upstream must keep a beat offered until it is taken.
  valid_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> valid_i);

  payload_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> $stable(payload_i));

  lfsr_nonzero_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lfsr_q != 16'h0000);
`endif

endmodule

// File: tb/tb_stream_ready_throttle.sv
// Bench for stream_ready_throttle. Four instances run concurrently under
// randomized traffic:
//   lane 0: FixedDelay=3, ready_i=1, first beat 8'hA5 at cycle 10
//   lane 1: FixedDelay=0, ready_i=1, back-to-back beats 0..7 first
//   lane 2: FixedDelay=1, ready_i=0 for the first 30 cycles, then random
//   lane 3: StallRandom=1 (seed 16'hACE1), 1000 beats, random ready_i
// A fifth instance (FixedDelay=6, own reset) gets a directed reset test.
// Reference model: a beat first offered at relative cycle 0 may be taken
// from relative cycle D onward, whenever the output register has space.

module tb_stream_ready_throttle;

  localparam int NL = 4;
  localparam logic [15:0] FD_P  = {4'd0, 4'd1, 4'd0, 4'd3};
  localparam logic [3:0]  RND_P = 4'b1000;
  localparam int LIMIT = 60000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NL-1:0] valid_i, ready_o, ready_i, valid_o;
  logic [7:0]    payload_i [NL];
  logic [7:0]    payload_o [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    stream_ready_throttle #(
      .StallRandom(RND_P[g]),
      .FixedDelay (int'(FD_P[4*g +: 4])),
      .LfsrSeed   (16'hACE1),
      .payload_t  (logic [7:0])
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .valid_i  (valid_i[g]),
      .ready_o  (ready_o[g]),
      .payload_i(payload_i[g]),
      .valid_o  (valid_o[g]),
      .ready_i  (ready_i[g]),
      .payload_o(payload_o[g])
    );
  end

  logic       rst4_n, valid4_i, ready4_o, valid4_o, ready4_i;
  logic [7:0] payload4_i, payload4_o;

  stream_ready_throttle #(
    .StallRandom(1'b0),
    .FixedDelay (6),
    .LfsrSeed   (16'hACE1),
    .payload_t  (logic [7:0])
  ) u_dut4 (
    .clk_i    (clk),
    .rst_ni   (rst4_n),
    .valid_i  (valid4_i),
    .ready_o  (ready4_o),
    .payload_i(payload4_i),
    .valid_o  (valid4_o),
    .ready_i  (ready4_i),
    .payload_o(payload4_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int lane, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %0h expected %0h (t=%0t)", name, lane, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic int nbeats(input int g);
    case (g)
      0: return 30;
      1: return 40;
      2: return 40;
      default: return 1000;
    endcase
  endfunction

  int cyc = 0;
  always @(posedge clk) if (rst_n) cyc++;

  logic [7:0] exp_q [NL][$];

  // Monitor / reference model
  bit          mon_en = 1'b0;
  bit          active [NL];
  bit          held   [NL];
  int          n_cyc  [NL];
  int          d_exp  [NL];
  logic [15:0] lfsr_m [NL];
  int          delivered [NL];
  int          zero_seen = 0;

  initial begin
    for (int g = 0; g < NL; g++) begin
      active[g] = 1'b0; held[g] = 1'b0; n_cyc[g] = 0; d_exp[g] = 0;
      lfsr_m[g] = 16'hACE1; delivered[g] = 0;
    end
  end

  always @(negedge clk) begin
    logic       er;
    logic       pop;
    logic       acc;
    logic [7:0] exp_pl;
    if (mon_en) begin
      for (int g = 0; g < NL; g++) begin
        if (valid_i[g] && !active[g]) begin
          active[g] = 1'b1;
          n_cyc[g]  = 0;
          d_exp[g]  = RND_P[g] ? int'(lfsr_m[g][3:0]) : int'(FD_P[4*g +: 4]);
          lfsr_m[g] = lfsr_next(lfsr_m[g]);
          if (RND_P[g] && d_exp[g] == 0) zero_seen++;
        end
        er = active[g] && (n_cyc[g] >= d_exp[g]) && (!held[g] || ready_i[g]);
        check("valid_o", g, int'(valid_o[g]), int'(held[g]));
        check("ready_o", g, int'(ready_o[g]), int'(er));
        pop = held[g] && ready_i[g];
        if (pop) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow lane%0d: got delivery, expected none", g);
          end else begin
            exp_pl = exp_q[g].pop_front();
            check("payload_o", g, int'(payload_o[g]), int'(exp_pl));
            delivered[g]++;
          end
        end
        acc = valid_i[g] && er;
        if (acc) held[g] = 1'b1;
        else if (pop) held[g] = 1'b0;
        if (acc) active[g] = 1'b0;
        else if (active[g]) n_cyc[g]++;
      end
    end
  end

  task automatic offer4(input logic [7:0] d, output int lat);
    valid4_i   = 1'b1;
    payload4_i = d;
    lat        = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready4_o) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid4_i = 1'b0;
  endtask

  // Driver
  int          issued   [NL];
  int          accepted [NL];
  logic [NL-1:0] acc_d;
  bit          all_done;
  logic [7:0]  pl;
  bit          go;
  int          lat;

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    valid_i = '0; ready_i = '0; acc_d = '0;
    valid4_i = 1'b0; ready4_i = 1'b0; payload4_i = 8'h00;
    for (int g = 0; g < NL; g++) begin
      payload_i[g] = 8'h00; issued[g] = 0; accepted[g] = 0;
    end
    #12;
    for (int g = 0; g < NL; g++) begin
      check("rst_valid_o", g, int'(valid_o[g]), 0);
      check("rst_ready_o", g, int'(ready_o[g]), 0);
      check("rst_payload_o", g, int'(payload_o[g]), 0);
    end
    check("rst_valid_o", 4, int'(valid4_o), 0);
    check("rst_ready_o", 4, int'(ready4_o), 0);
    @(negedge clk);
    rst_n = 1'b1; rst4_n = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;

    all_done = 1'b0;
    while (!all_done && cyc < LIMIT) begin
      for (int g = 0; g < NL; g++) begin
        if (acc_d[g]) begin
          valid_i[g] = 1'b0;
          accepted[g]++;
        end
        case (g)
          0: go = (issued[0] == 0) ? (cyc >= 10) : ($urandom_range(0, 2) != 0);
          1: go = 1'b1;
          default: go = ($urandom_range(0, 3) != 0);
        endcase
        if (!valid_i[g] && issued[g] < nbeats(g) && go) begin
          if (g == 0 && issued[g] == 0) pl = 8'hA5;
          else if (g == 1 && issued[g] < 8) pl = 8'(issued[g]);
          else pl = 8'($urandom);
          valid_i[g]   = 1'b1;
          payload_i[g] = pl;
          exp_q[g].push_back(pl);
          issued[g]++;
        end
        case (g)
          0, 1: ready_i[g] = 1'b1;
          2: ready_i[g] = (cyc < 30) ? 1'b0 : 1'($urandom_range(0, 1));
          default: ready_i[g] = ($urandom_range(0, 3) != 0);
        endcase
      end
      all_done = 1'b1;
      for (int g = 0; g < NL; g++) if (accepted[g] < nbeats(g)) all_done = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NL; g++) acc_d[g] = valid_i[g] && ready_o[g];
      @(posedge clk); #1;
    end
    check("all_beats_accepted", 0, int'(all_done), 1);

    ready_i = '1;
    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < NL; g++) begin
      check("sb_empty", g, exp_q[g].size(), 0);
      check("delivered", g, delivered[g], nbeats(g));
    end
    check("delay0_seen", 3, int'(zero_seen > 0), 1);

    // Directed reset test on the FixedDelay=6 instance.
    ready4_i = 1'b0;
    offer4(8'h3C, lat);
    check("lat_first", 4, lat, 6);
    check("held_valid", 4, int'(valid4_o), 1);
    check("held_data", 4, int'(payload4_o), 8'h3C);
    valid4_i   = 1'b1;
    payload4_i = 8'h5A;
    @(posedge clk); #1;
    check("stall_ready", 4, int'(ready4_o), 0);
    #2 rst4_n = 1'b0;
    #1;
    check("rst_mid_valid_o", 4, int'(valid4_o), 0);
    check("rst_mid_ready_o", 4, int'(ready4_o), 0);
    check("rst_mid_payload_o", 4, int'(payload4_o), 0);
    valid4_i = 1'b0;
    @(posedge clk); #3 rst4_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid_o", 4, int'(valid4_o), 0);
    offer4(8'h77, lat);
    check("lat_post_rst", 4, lat, 6);
    check("post_rst_valid", 4, int'(valid4_o), 1);
    check("post_rst_data", 4, int'(payload4_o), 8'h77);
    ready4_i = 1'b1;
    @(posedge clk); #1;
    check("post_pop_valid", 4, int'(valid4_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
